// File: rtl/gold_seq_pkg.sv
// Shared types and constants for the Gold sequence arbiter: FSM states,
// LFSR geometry, feedback tap masks and the PBCH DMRS c_init helper.
package gold_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WARMUP,
    ST_STREAM,
    ST_DONE
  } state_t;

  localparam int NC_DEFAULT = 1600;
  localparam int LFSR_N     = 31;

  // Bit i of a tap mask selects x(n+i) into the x(n+31) feedback term.
  localparam logic [LFSR_N-1:0] X1_TAPS = 31'h0000_0009;
  localparam logic [LFSR_N-1:0] X2_TAPS = 31'h0000_000F;

  localparam int PBCH_CINIT_HI_SHIFT = 11;
  localparam int PBCH_CINIT_LO_SHIFT = 6;

  // PBCH DMRS: c_init = 2^11*(ibar+1)*(floor(N_id/4)+1) + 2^6*(ibar+1) + (N_id mod 4)
  function automatic logic [LFSR_N-1:0] pbch_dmrs_c_init(input logic [9:0] n_id,
                                                         input logic [2:0] i_bar);
    logic [LFSR_N-1:0] ib1;
    logic [LFSR_N-1:0] nq1;
    ib1 = LFSR_N'(i_bar) + LFSR_N'(1);
    nq1 = LFSR_N'(n_id[9:2]) + LFSR_N'(1);
    return ((ib1 * nq1) << PBCH_CINIT_HI_SHIFT) + (ib1 << PBCH_CINIT_LO_SHIFT)
           + LFSR_N'(n_id[1:0]);
  endfunction

endpackage

// File: rtl/gold_seq_gen.sv
// Pair of 31-bit Fibonacci LFSRs forming the shared Gold sequence generator;
// bit i of each register holds x(n+i), so the output is x1(n) ^ x2(n).
module gold_seq_gen
  import gold_seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              load_i,
  input  logic [LFSR_N-1:0] c_init_i,
  input  logic              en_i,
  output logic              bit_o
);

  logic [LFSR_N-1:0] r_x1;
  logic [LFSR_N-1:0] r_x2;
  logic              w_fb1;
  logic              w_fb2;

  assign w_fb1 = ^(r_x1 & X1_TAPS);
  assign w_fb2 = ^(r_x2 & X2_TAPS);

  // Load takes priority so a fresh grant always restarts from n = 0.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_x1 <= '0;
      r_x2 <= '0;
    end else if (load_i) begin
      r_x1 <= LFSR_N'(1);
      r_x2 <= c_init_i;
    end else if (en_i) begin
      r_x1 <= {w_fb1, r_x1[LFSR_N-1:1]};
      r_x2 <= {w_fb2, r_x2[LFSR_N-1:1]};
    end
  end

  assign bit_o = r_x1[0] ^ r_x2[0];

endmodule

// File: rtl/gold_seq_arbiter.sv
// Arbitrates NUM_REQ requesters onto one Gold generator and streams the
// sequence over AXI-stream. Define GOLD_SEQ_ARB_FIXED_PRIO_EN for fixed priority.
module gold_seq_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int LFSR_N  = 31,
  parameter int NC      = 1600,
  parameter int LEN_W   = 11
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*LFSR_N-1:0]  c_init_i,
  input  logic [NUM_REQ*LEN_W-1:0]   len_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic                       busy_o,
  output logic                       m_axis_seq_tdata,
  output logic                       m_axis_seq_tvalid,
  input  logic                       m_axis_seq_tready,
  output logic                       m_axis_seq_tlast,
  output logic [$clog2(NUM_REQ)-1:0] m_axis_seq_tuser,
  output logic                       done_o
);

  import gold_seq_pkg::*;

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (LEN_W > 11) ? LEN_W : 11;

  state_t            r_state;
  state_t            w_next;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   w_win_id;
  logic              w_any;
  logic [LEN_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_cnt;
  logic [LFSR_N-1:0] w_cinit_sel;
  logic [LEN_W-1:0]  w_len_sel;
  logic              w_gen_bit;
  logic              w_load;
  logic              w_en;
  logic              w_valid;
  logic              w_hs;
  logic              w_last;
  logic              w_warm_end;

`ifdef GOLD_SEQ_ARB_FIXED_PRIO_EN
  // Scan downwards so the lowest requesting index is the final assignment.
  always_comb begin
    w_any    = 1'b0;
    w_win_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        w_any    = 1'b1;
        w_win_id = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] r_last;

  always_comb begin
    int idx;
    idx      = 0;
    w_any    = 1'b0;
    w_win_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(r_last) + 1 + i) % NUM_REQ;
      if (!w_any && req_i[idx]) begin
        w_any    = 1'b1;
        w_win_id = ID_W'(idx);
      end
    end
  end

  // Starts at NUM_REQ-1 so requester 0 is first in line after reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_last <= ID_W'(NUM_REQ - 1);
    end else if (r_state == ST_IDLE && w_any) begin
      r_last <= w_win_id;
    end
  end
`endif

  assign w_cinit_sel = c_init_i[int'(r_id)*LFSR_N +: LFSR_N];
  assign w_len_sel   = len_i[int'(r_id)*LEN_W +: LEN_W];
  assign w_warm_end  = (r_cnt == CNT_W'(NC - 1));
  assign w_valid     = (r_state == ST_STREAM);
  assign w_hs        = w_valid & m_axis_seq_tready;
  assign w_last      = (r_cnt == CNT_W'(r_len - LEN_W'(1)));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_next = ST_LOAD;
      ST_LOAD:   w_next = (w_len_sel == '0) ? ST_DONE : ST_WARMUP;
      ST_WARMUP: if (w_warm_end) w_next = ST_STREAM;
      ST_STREAM: if (w_hs && w_last) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // One counter serves both warm-up and bit index; it is cleared on entry to each phase.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_any) r_id <= w_win_id;
        end
        ST_LOAD: begin
          r_len <= w_len_sel;
          r_cnt <= '0;
        end
        ST_WARMUP: begin
          r_cnt <= w_warm_end ? '0 : r_cnt + CNT_W'(1);
        end
        ST_STREAM: begin
          if (w_hs) r_cnt <= r_cnt + CNT_W'(1);
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign w_load = (r_state == ST_LOAD);
  assign w_en   = (r_state == ST_WARMUP) | w_hs;

  gold_seq_gen u_gen (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .load_i   (w_load),
    .c_init_i (w_cinit_sel),
    .en_i     (w_en),
    .bit_o    (w_gen_bit)
  );

  always_comb begin
    grant_o = '0;
    if (r_state == ST_LOAD) grant_o[r_id] = 1'b1;
  end

  assign busy_o            = (r_state != ST_IDLE);
  assign m_axis_seq_tvalid = w_valid;
  assign m_axis_seq_tdata  = w_valid & w_gen_bit;
  assign m_axis_seq_tlast  = w_valid & w_last;
  assign m_axis_seq_tuser  = r_id;
  assign done_o            = (r_state == ST_DONE);

endmodule
